// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//  Bundles the sequencer's inputs (run, Inst, flags) and every strobe it
//  drives towards the register, ALU, memory and program-control units.
//  master : the sequencer (consumes run/Inst/flags, drives the strobes)
//  slave  : the datapath side (drives run/Inst/flags, consumes the strobes)
interface control_sequencer_if;
  logic       run;
  logic [7:0] Inst;
  logic [2:0] flags;
  logic [7:0] LdReg;
  logic [7:0] SelReg;
  logic       LdXY;
  logic [4:0] PcLd;
  logic [4:0] AddrSel;
  logic       MemRead;
  logic       MemWrite;
  logic [2:0] AluFunctionCode;
  logic       LdFlags;
  logic [7:0] Imm;
  logic       ImmEn;
  logic       Halted;
  logic [3:0] state;

  modport master (
    input  run, Inst, flags,
    output LdReg, SelReg, LdXY, PcLd, AddrSel, MemRead, MemWrite,
           AluFunctionCode, LdFlags, Imm, ImmEn, Halted, state
  );

  modport slave (
    output run, Inst, flags,
    input  LdReg, SelReg, LdXY, PcLd, AddrSel, MemRead, MemWrite,
           AluFunctionCode, LdFlags, Imm, ImmEn, Halted, state
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//  Instruction sequencer FSM for the relay computer: fetches an opcode via the
//  program-control path, decodes it and drives the register/ALU/memory strobes.
//  Ports:
//    clk    - system clock, all state changes on the rising edge
//    rst_n  - synchronous active-low reset
//    bus    - control_sequencer_if.master: run/Inst/flags in, strobes and
//             debug state code out
//  Parameter MEM_WAIT (0..3) adds hold cycles to every memory-access state.
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, INCPC = 4'd2, DECODE = 4'd3, EXEC1 = 4'd4,
    EXEC2 = 4'd5, J1RD = 4'd6, J1INC = 4'd7, J2RD = 4'd8, J2INC = 4'd9,
    JUMP = 4'd10, HALT = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    OP_MOV, OP_SETAB, OP_ALU, OP_MEM, OP_INCXY, OP_HALT, OP_GOTO, OP_NOP
  } op_t;

  typedef struct packed {
    logic [7:0] ld_reg;
    logic [7:0] sel_reg;
    logic       ld_xy;
    logic [4:0] pc_ld;
    logic [4:0] addr_sel;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_fn;
    logic       ld_flags;
    logic [7:0] imm;
    logic       imm_en;
    logic       halted;
  } outs_t;

  // PcLd = {LdJ1,LdJ2,LdInst,LdPC,LdINC}, AddrSel = {SelM,SelXY,SelJ,SelPC,SelINC}
  localparam logic [4:0] PC_LDJ1   = 5'b10000;
  localparam logic [4:0] PC_LDJ2   = 5'b01000;
  localparam logic [4:0] PC_LDINST = 5'b00100;
  localparam logic [4:0] PC_LDPC   = 5'b00010;
  localparam logic [4:0] PC_LDINC  = 5'b00001;
  localparam logic [4:0] AS_M      = 5'b10000;
  localparam logic [4:0] AS_XY     = 5'b01000;
  localparam logic [4:0] AS_J      = 5'b00100;
  localparam logic [4:0] AS_PC     = 5'b00010;
  localparam logic [4:0] AS_INC    = 5'b00001;
  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

  state_t     cur, nxt, after;
  logic [7:0] ir, nxt_ir;
  logic [1:0] wcnt, nxt_wcnt;
  logic       last_hold, jump_taken;
  op_t        cur_op;
  outs_t      out_q, nxt_out;

  function automatic op_t classify(input logic [7:0] op);
    op_t c;
    if (op[7:6] == 2'b00)                     c = OP_MOV;
    else if (op[7:6] == 2'b01)                c = OP_SETAB;
    else if (op[7:4] == 4'b1000)              c = OP_ALU;
    else if (op[7:4] == 4'b1001 && !op[2])    c = OP_MEM;
    else if (op == 8'hB0)                     c = OP_INCXY;
    else if (op == 8'hAE)                     c = OP_HALT;
    else if (op[7:6] == 2'b11 && op[4:3] == 2'b00) c = OP_GOTO;
    else                                      c = OP_NOP;
    return c;
  endfunction

  // Strobe pattern for a given state; 'last' marks the final cycle of a hold
  // state, which is the only cycle on which its Ld* strobes may fire.
  function automatic outs_t decode_outs(input state_t s, input logic [7:0] i,
                                        input logic last, input logic tk);
    outs_t o;
    o = '0;
    case (s)
      FETCH, J1RD, J2RD: begin
        o.addr_sel = AS_PC;
        o.mem_read = 1'b1;
        if (last)
          o.pc_ld = PC_LDINC | ((s == FETCH) ? PC_LDINST : (s == J1RD) ? PC_LDJ1 : PC_LDJ2);
      end
      INCPC, J1INC, J2INC: begin
        o.addr_sel = AS_INC;
        o.pc_ld    = PC_LDPC;
      end
      EXEC1: begin
        case (classify(i))
          OP_MOV: begin
            o.ld_reg[i[5:3]] = 1'b1;
            // Moving a register onto itself drives nothing, so it loads 0.
            if (i[2:0] != i[5:3]) o.sel_reg[i[2:0]] = 1'b1;
          end
          OP_SETAB: begin
            o.imm    = {{3{i[4]}}, i[4:0]};
            o.imm_en = 1'b1;
            o.ld_reg[{2'b00, i[5]}] = 1'b1;
          end
          OP_ALU: begin
            o.alu_fn   = i[2:0];
            o.ld_flags = 1'b1;
            o.ld_reg   = i[3] ? 8'h08 : 8'h01;
          end
          OP_MEM: begin
            o.addr_sel = AS_M;
            if (i[3]) begin
              o.sel_reg[{1'b0, i[1:0]}] = 1'b1;
              o.mem_write = 1'b1;
            end else begin
              o.mem_read = 1'b1;
              if (last) o.ld_reg[{1'b0, i[1:0]}] = 1'b1;
            end
          end
          OP_INCXY: begin
            o.addr_sel = AS_XY;
            o.pc_ld    = PC_LDINC;
          end
          default: o = '0;
        endcase
      end
      EXEC2: begin
        o.addr_sel = AS_INC;
        o.ld_xy    = 1'b1;
      end
      JUMP: begin
        if (tk) begin
          o.addr_sel = AS_J;
          o.pc_ld    = PC_LDPC;
        end
      end
      HALT:    o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  assign cur_op    = classify(ir);
  assign last_hold = (wcnt == WAIT_LAST);
  assign after     = bus.run ? FETCH : IDLE;
  // Outputs are registered one state ahead, so the JUMP decision is taken
  // from the flags present on the edge that enters JUMP.
  assign jump_taken = ~ir[5] | (|(ir[2:0] & bus.flags));

  // Next-state, opcode capture and hold-counter logic.
  always_comb begin
    nxt      = cur;
    nxt_ir   = ir;
    nxt_wcnt = 2'd0;
    case (cur)
      IDLE:   if (bus.run) nxt = FETCH;
      FETCH:  if (last_hold) nxt = INCPC; else nxt_wcnt = wcnt + 2'd1;
      INCPC:  nxt = DECODE;
      DECODE: begin
        nxt_ir = bus.Inst;
        case (classify(bus.Inst))
          OP_HALT: nxt = HALT;
          OP_GOTO: nxt = J1RD;
          OP_NOP:  nxt = after;
          default: nxt = EXEC1;
        endcase
      end
      EXEC1: begin
        if (cur_op == OP_INCXY)                   nxt = EXEC2;
        else if (cur_op == OP_MEM && !last_hold)  nxt_wcnt = wcnt + 2'd1;
        else                                      nxt = after;
      end
      EXEC2:  nxt = after;
      J1RD:   if (last_hold) nxt = J1INC; else nxt_wcnt = wcnt + 2'd1;
      J1INC:  nxt = J2RD;
      J2RD:   if (last_hold) nxt = J2INC; else nxt_wcnt = wcnt + 2'd1;
      J2INC:  nxt = JUMP;
      JUMP:   nxt = after;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
    nxt_out = decode_outs(nxt, nxt_ir, (nxt_wcnt == WAIT_LAST), jump_taken);
  end

  // State, captured opcode, hold counter and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= IDLE;
      ir    <= 8'h00;
      wcnt  <= 2'd0;
      out_q <= '0;
    end else begin
      cur   <= nxt;
      ir    <= nxt_ir;
      wcnt  <= nxt_wcnt;
      out_q <= nxt_out;
    end
  end

  assign bus.LdReg           = out_q.ld_reg;
  assign bus.SelReg          = out_q.sel_reg;
  assign bus.LdXY            = out_q.ld_xy;
  assign bus.PcLd            = out_q.pc_ld;
  assign bus.AddrSel         = out_q.addr_sel;
  assign bus.MemRead         = out_q.mem_read;
  assign bus.MemWrite        = out_q.mem_write;
  assign bus.AluFunctionCode = out_q.alu_fn;
  assign bus.LdFlags         = out_q.ld_flags;
  assign bus.Imm             = out_q.imm;
  assign bus.ImmEn           = out_q.imm_en;
  assign bus.Halted          = out_q.halted;
  assign bus.state           = cur;

  a_addrsel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.AddrSel));
  a_selreg_onehot0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.SelReg));
  a_mem_exclusive:   assert property (@(posedge clk) disable iff (!rst_n) !(bus.MemRead && bus.MemWrite));

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//  Directed bench for control_sequencer. dut0 runs with MEM_WAIT=0, dut1 with
//  MEM_WAIT=2 to exercise the memory hold cycles. Outputs are sampled 1 time
//  unit after each rising edge.
module tb_control_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  control_sequencer_if if0 ();
  control_sequencer_if if1 ();

  control_sequencer #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  control_sequencer #(.MEM_WAIT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every strobe of dut0 packed together (state code excluded)
  function automatic logic [42:0] outs0();
    return {if0.LdReg, if0.SelReg, if0.LdXY, if0.PcLd, if0.AddrSel, if0.MemRead,
            if0.MemWrite, if0.AluFunctionCode, if0.LdFlags, if0.Imm, if0.ImmEn, if0.Halted};
  endfunction

  // From IDLE: present an opcode with run=1 and step into DECODE
  task automatic fetch_to_decode(input logic [7:0] op);
    if0.Inst = op;
    if0.run  = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.run = 1'b1; if1.run = 1'b1;
    step(); step();
    checks++; if (if0.state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state0 got=%0d exp=0", if0.state); end
    checks++; if (outs0() !== 43'd0) begin errors++; $display("[TB] FAIL reset_outs0 got=%h exp=0", outs0()); end
    checks++; if (if1.state !== 4'd0 || if1.MemRead !== 1'b0 || if1.PcLd !== 5'd0) begin
      errors++; $display("[TB] FAIL reset_dut1 got state=%0d MemRead=%b PcLd=%h exp 0/0/0", if1.state, if1.MemRead, if1.PcLd); end
    if1.run = 1'b0;
    if0.Inst = 8'h08;
    rst_n = 1'b1;
  endtask

  task automatic test_mov();
    step();
    checks++; if (if0.state !== 4'd1 || if0.MemRead !== 1'b1 || if0.AddrSel !== 5'h02 || if0.PcLd !== 5'h05) begin
      errors++; $display("[TB] FAIL mov_fetch got state=%0d MemRead=%b AddrSel=%h PcLd=%h exp 1/1/02/05", if0.state, if0.MemRead, if0.AddrSel, if0.PcLd); end
    step();
    checks++; if (if0.state !== 4'd2 || if0.AddrSel !== 5'h01 || if0.PcLd !== 5'h02) begin
      errors++; $display("[TB] FAIL mov_incpc got state=%0d AddrSel=%h PcLd=%h exp 2/01/02", if0.state, if0.AddrSel, if0.PcLd); end
    step();
    checks++; if (if0.state !== 4'd3 || outs0() !== 43'd0) begin
      errors++; $display("[TB] FAIL mov_decode got state=%0d outs=%h exp 3/0", if0.state, outs0()); end
    step();
    checks++; if (if0.state !== 4'd4 || if0.SelReg !== 8'h01 || if0.LdReg !== 8'h02) begin
      errors++; $display("[TB] FAIL mov_exec got state=%0d SelReg=%h LdReg=%h exp 4/01/02", if0.state, if0.SelReg, if0.LdReg); end
    if0.Inst = 8'h12;
    step();
    checks++; if (if0.state !== 4'd1) begin errors++; $display("[TB] FAIL mov_refetch got=%0d exp=1", if0.state); end
    step(); step(); step();
    checks++; if (if0.state !== 4'd4 || if0.SelReg !== 8'h00 || if0.LdReg !== 8'h04) begin
      errors++; $display("[TB] FAIL mov_self got state=%0d SelReg=%h LdReg=%h exp 4/00/04", if0.state, if0.SelReg, if0.LdReg); end
    if0.run = 1'b0;
    step();
    checks++; if (if0.state !== 4'd0 || outs0() !== 43'd0) begin
      errors++; $display("[TB] FAIL mov_to_idle got state=%0d outs=%h exp 0/0", if0.state, outs0()); end
  endtask

  task automatic test_setab();
    fetch_to_decode(8'h5F);
    step();
    checks++; if (if0.Imm !== 8'hFF || if0.ImmEn !== 1'b1 || if0.LdReg !== 8'h01) begin
      errors++; $display("[TB] FAIL setab_neg got Imm=%h ImmEn=%b LdReg=%h exp FF/1/01", if0.Imm, if0.ImmEn, if0.LdReg); end
    if0.Inst = 8'h4F;
    step(); step(); step(); step();
    checks++; if (if0.state !== 4'd4 || if0.Imm !== 8'h0F || if0.ImmEn !== 1'b1 || if0.LdReg !== 8'h01) begin
      errors++; $display("[TB] FAIL setab_pos got state=%0d Imm=%h ImmEn=%b LdReg=%h exp 4/0F/1/01", if0.state, if0.Imm, if0.ImmEn, if0.LdReg); end
    if0.run = 1'b0;
    step();
  endtask

  task automatic test_alu_store_nop();
    fetch_to_decode(8'h8B);
    step();
    checks++; if (if0.AluFunctionCode !== 3'd3 || if0.LdFlags !== 1'b1 || if0.LdReg !== 8'h08) begin
      errors++; $display("[TB] FAIL alu got fn=%0d LdFlags=%b LdReg=%h exp 3/1/08", if0.AluFunctionCode, if0.LdFlags, if0.LdReg); end
    if0.run = 1'b0;
    step();
    fetch_to_decode(8'h9A);
    step();
    checks++; if (if0.AddrSel !== 5'h10 || if0.SelReg !== 8'h04 || if0.MemWrite !== 1'b1 || if0.MemRead !== 1'b0 || if0.LdReg !== 8'h00) begin
      errors++; $display("[TB] FAIL store got AddrSel=%h SelReg=%h MemWrite=%b MemRead=%b LdReg=%h exp 10/04/1/0/00",
                         if0.AddrSel, if0.SelReg, if0.MemWrite, if0.MemRead, if0.LdReg); end
    if0.run = 1'b0;
    step();
    fetch_to_decode(8'hA0);
    if0.run = 1'b0;
    step();
    checks++; if (if0.state !== 4'd0 || outs0() !== 43'd0) begin
      errors++; $display("[TB] FAIL nop got state=%0d outs=%h exp 0/0", if0.state, outs0()); end
  endtask

  task automatic test_mem_wait();
    if1.Inst = 8'h91;
    if1.run  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if1.run = 1'b0;
      checks++; if (if1.state !== 4'd1 || if1.MemRead !== 1'b1 || if1.AddrSel !== 5'h02 || if1.PcLd[2] !== (c == 2)) begin
        errors++; $display("[TB] FAIL wait_fetch%0d got state=%0d MemRead=%b AddrSel=%h LdInst=%b exp 1/1/02/%b",
                           c, if1.state, if1.MemRead, if1.AddrSel, if1.PcLd[2], (c == 2)); end
    end
    step();
    checks++; if (if1.state !== 4'd2) begin errors++; $display("[TB] FAIL wait_incpc got=%0d exp=2", if1.state); end
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (if1.state !== 4'd4 || if1.MemRead !== 1'b1 || if1.AddrSel !== 5'h10 || if1.LdReg !== ((c == 2) ? 8'h02 : 8'h00)) begin
        errors++; $display("[TB] FAIL wait_load%0d got state=%0d MemRead=%b AddrSel=%h LdReg=%h exp 4/1/10/%h",
                           c, if1.state, if1.MemRead, if1.AddrSel, if1.LdReg, (c == 2) ? 8'h02 : 8'h00); end
    end
    step();
    checks++; if (if1.state !== 4'd0) begin errors++; $display("[TB] FAIL wait_idle got=%0d exp=0", if1.state); end
  endtask

  task automatic test_goto();
    logic [7:0] ops [3];
    logic [2:0] flg [3];
    logic       tk  [3];
    logic [3:0] seq [8];
    ops = '{8'hE1, 8'hE1, 8'hC0};
    flg = '{3'b000, 3'b001, 3'b000};
    tk  = '{1'b0, 1'b1, 1'b1};
    seq = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    for (int k = 0; k < 3; k++) begin
      if0.Inst  = ops[k];
      if0.flags = flg[k];
      if0.run   = 1'b1;
      for (int c = 0; c < 8; c++) begin
        step();
        checks++; if (if0.state !== seq[c]) begin
          errors++; $display("[TB] FAIL goto%0d_seq%0d got=%0d exp=%0d", k, c, if0.state, seq[c]); end
        if (c == 3) begin
          checks++; if (if0.PcLd !== 5'h11 || if0.MemRead !== 1'b1) begin
            errors++; $display("[TB] FAIL goto%0d_j1rd got PcLd=%h MemRead=%b exp 11/1", k, if0.PcLd, if0.MemRead); end
        end
        if (c == 5) begin
          checks++; if (if0.PcLd !== 5'h09) begin
            errors++; $display("[TB] FAIL goto%0d_j2rd got PcLd=%h exp 09", k, if0.PcLd); end
        end
      end
      checks++; if (if0.AddrSel !== (tk[k] ? 5'h04 : 5'h00) || if0.PcLd !== (tk[k] ? 5'h02 : 5'h00)) begin
        errors++; $display("[TB] FAIL goto%0d_jump got AddrSel=%h PcLd=%h exp taken=%b", k, if0.AddrSel, if0.PcLd, tk[k]); end
      if0.run = 1'b0;
      step();
      if0.flags = 3'b000;
    end
  endtask

  task automatic test_halt_reset();
    fetch_to_decode(8'hAE);
    step();
    checks++; if (if0.state !== 4'd11 || if0.Halted !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_enter got state=%0d Halted=%b exp 11/1", if0.state, if0.Halted); end
    for (int c = 0; c < 20; c++) begin
      if0.run = c[0];
      step();
      checks++; if (if0.state !== 4'd11 || if0.Halted !== 1'b1) begin
        errors++; $display("[TB] FAIL halt_hold%0d got state=%0d Halted=%b exp 11/1", c, if0.state, if0.Halted); end
    end
    rst_n = 1'b0;
    if0.run = 1'b0;
    step();
    checks++; if (if0.state !== 4'd0 || outs0() !== 43'd0) begin
      errors++; $display("[TB] FAIL halt_reset got state=%0d outs=%h exp 0/0", if0.state, outs0()); end
    rst_n = 1'b1;
    fetch_to_decode(8'hB0);
    step();
    checks++; if (if0.state !== 4'd4 || if0.AddrSel !== 5'h08 || if0.PcLd !== 5'h01) begin
      errors++; $display("[TB] FAIL incxy_exec1 got state=%0d AddrSel=%h PcLd=%h exp 4/08/01", if0.state, if0.AddrSel, if0.PcLd); end
    step();
    checks++; if (if0.state !== 4'd5 || if0.AddrSel !== 5'h01 || if0.LdXY !== 1'b1) begin
      errors++; $display("[TB] FAIL incxy_exec2 got state=%0d AddrSel=%h LdXY=%b exp 5/01/1", if0.state, if0.AddrSel, if0.LdXY); end
    rst_n = 1'b0;
    step();
    checks++; if (if0.state !== 4'd0 || outs0() !== 43'd0) begin
      errors++; $display("[TB] FAIL incxy_reset got state=%0d outs=%h exp 0/0", if0.state, outs0()); end
    rst_n = 1'b1;
  endtask

  // Main sequence
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if0.run = 1'b0; if0.Inst = 8'h00; if0.flags = 3'b000;
    if1.run = 1'b0; if1.Inst = 8'h00; if1.flags = 3'b000;
    test_reset();
    test_mov();
    test_setab();
    test_alu_store_nop();
    test_mem_wait();
    test_goto();
    test_halt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
